// File: rtl/ppt_regbank.sv
// rtl/ppt_regbank.sv - multi-channel PPT register bank with atomic 16-bit config and sticky done irq
module ppt_regbank #(
    parameter int          N_CH   = 2,
    parameter int          ADDR_W = 6,
    parameter logic [7:0]  ID_VAL = 8'hA2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    address,
    input  logic [7:0]           data_in,
    input  logic                 write_enable,
    input  logic                 read_enable,
    output logic [7:0]           data_out,
    output logic [5*N_CH-1:0]    clk_div,
    output logic [16*N_CH-1:0]   period,
    output logic [16*N_CH-1:0]   width,
    output logic [16*N_CH-1:0]   count,
    output logic [N_CH-1:0]      run_ppt,
    output logic [N_CH-1:0]      start_ppt,
    input  logic [16*N_CH-1:0]   count_done,
    input  logic [N_CH-1:0]      done,
    output logic                 irq
);

    localparam int BLK_W = ADDR_W - 4;

    logic [BLK_W-1:0] blk;
    logic [3:0]       off;
    assign blk = address[ADDR_W-1:4];
    assign off = address[3:0];

    logic [7:0]  clk_div_q  [N_CH];
    logic [15:0] period_q   [N_CH];
    logic [15:0] width_q    [N_CH];
    logic [15:0] count_q    [N_CH];
    logic [7:0]  period_stg [N_CH];
    logic [7:0]  width_stg  [N_CH];
    logic [7:0]  count_stg  [N_CH];
    logic [7:0]  snap_q     [N_CH];
    logic [N_CH-1:0] run_q, start_q, irq_en_q, irq_status_q, done_q;
    logic [N_CH-1:0] irq_set, irq_clr;
    logic [7:0]  data_out_q, rd_data;
    logic        irq_q;

    assign irq_set = done & ~done_q;
    assign irq_clr = (write_enable && blk == '0 && off == 4'h3) ? data_in[N_CH-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                clk_div_q[c]  <= 8'd9;
                period_q[c]   <= 16'd128;
                width_q[c]    <= 16'd1;
                count_q[c]    <= 16'd16;
                period_stg[c] <= 8'h80;
                width_stg[c]  <= 8'h01;
                count_stg[c]  <= 8'h10;
                snap_q[c]     <= 8'h00;
            end
            run_q        <= '0;
            start_q      <= '0;
            irq_en_q     <= '0;
            irq_status_q <= '0;
            done_q       <= '0;
            irq_q        <= 1'b0;
            data_out_q   <= 8'h00;
        end else begin
            start_q      <= '0;
            done_q       <= done;
            // set is OR-ed after the clear so a coincident edge keeps the bit
            irq_status_q <= (irq_status_q & ~irq_clr) | irq_set;
            irq_q        <= |(irq_status_q & irq_en_q);
            if (read_enable)
                data_out_q <= rd_data;
            if (write_enable && blk == '0 && off == 4'h2)
                irq_en_q <= data_in[N_CH-1:0];
            for (int c = 0; c < N_CH; c++) begin
                if (write_enable && blk == BLK_W'(c + 1)) begin
                    case (off)
                        4'h0: clk_div_q[c]  <= data_in;
                        4'h1: period_stg[c] <= data_in;
                        4'h2: period_q[c]   <= {data_in, period_stg[c]};
                        4'h3: width_stg[c]  <= data_in;
                        4'h4: width_q[c]    <= {data_in, width_stg[c]};
                        4'h5: count_stg[c]  <= data_in;
                        4'h6: count_q[c]    <= {data_in, count_stg[c]};
                        4'h7: begin
                            run_q[c]   <= data_in[0];
                            start_q[c] <= data_in[1];
                        end
                        default: ;
                    endcase
                end
                if (read_enable && blk == BLK_W'(c + 1) && off == 4'h8)
                    snap_q[c] <= count_done[16*c+8 +: 8];
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        if (blk == '0) begin
            case (off)
                4'h0: rd_data = ID_VAL;
                4'h1: rd_data = 8'(N_CH);
                4'h2: rd_data[N_CH-1:0] = irq_en_q;
                4'h3: rd_data[N_CH-1:0] = irq_status_q;
                default: ;
            endcase
        end
        for (int c = 0; c < N_CH; c++) begin
            if (blk == BLK_W'(c + 1)) begin
                case (off)
                    4'h0: rd_data = clk_div_q[c];
                    4'h1: rd_data = period_q[c][7:0];
                    4'h2: rd_data = period_q[c][15:8];
                    4'h3: rd_data = width_q[c][7:0];
                    4'h4: rd_data = width_q[c][15:8];
                    4'h5: rd_data = count_q[c][7:0];
                    4'h6: rd_data = count_q[c][15:8];
                    4'h7: rd_data = {7'b0, run_q[c]};
                    4'h8: rd_data = count_done[16*c +: 8];
                    4'h9: rd_data = snap_q[c];
                    4'hA: rd_data = {7'b0, done[c]};
                    default: ;
                endcase
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_out
            assign clk_div[5*g +: 5]  = clk_div_q[g][4:0];
            assign period[16*g +: 16] = period_q[g];
            assign width[16*g +: 16]  = width_q[g];
            assign count[16*g +: 16]  = count_q[g];
        end
    endgenerate

    assign run_ppt   = run_q;
    assign start_ppt = start_q;
    assign data_out  = data_out_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_ppt_regbank.sv
// tb/tb_ppt_regbank.sv - scoreboard bench for ppt_regbank
module tb_ppt_regbank;

    localparam int N_CH = 2;
    localparam int ADDR_W = 6;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [ADDR_W-1:0]    address = '0;
    logic [7:0]           data_in = '0;
    logic                 write_enable = 1'b0;
    logic                 read_enable = 1'b0;
    logic [7:0]           data_out;
    logic [5*N_CH-1:0]    clk_div;
    logic [16*N_CH-1:0]   period, width, count;
    logic [N_CH-1:0]      run_ppt, start_ppt;
    logic [16*N_CH-1:0]   count_done = '0;
    logic [N_CH-1:0]      done = '0;
    logic                 irq;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    string      name_q[$];

    ppt_regbank #(.N_CH(N_CH), .ADDR_W(ADDR_W), .ID_VAL(8'hA2)) dut (
        .clk(clk), .rst(rst), .address(address), .data_in(data_in),
        .write_enable(write_enable), .read_enable(read_enable), .data_out(data_out),
        .clk_div(clk_div), .period(period), .width(width), .count(count),
        .run_ppt(run_ppt), .start_ppt(start_ppt), .count_done(count_done),
        .done(done), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        address = a;
        data_in = d;
        write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [7:0] exp, input string nm);
        address = a;
        read_enable = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        @(negedge clk);
        read_enable = 1'b0;
    endtask

    // Monitor: every edge that sees read_enable yields one data_out to compare.
    initial begin
        logic [7:0] e;
        string n;
        forever begin
            @(posedge clk);
            if (read_enable) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_read: got 0x%0h with empty scoreboard", data_out);
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    chk(n, {24'b0, data_out}, {24'b0, e});
                end
            end
        end
    end

    initial begin
        logic [7:0] rst_vals [8];
        rst_vals = '{8'd9, 8'd128, 8'd0, 8'd1, 8'd0, 8'd16, 8'd0, 8'd0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_start", {30'b0, start_ppt}, 32'd0);
        chk("rst_run", {30'b0, run_ppt}, 32'd0);
        chk("rst_period", period, {16'd128, 16'd128});
        chk("rst_clk_div", {22'b0, clk_div}, {22'b0, 5'd9, 5'd9});
        chk("rst_data_out", {24'b0, data_out}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            rd(ADDR_W'(8'h10 + i), rst_vals[i], $sformatf("ch0_rst_off%0d", i));
            rd(ADDR_W'(8'h20 + i), rst_vals[i], $sformatf("ch1_rst_off%0d", i));
        end
        rd(6'h00, 8'hA2, "id");
        rd(6'h01, 8'h02, "n_ch");

        // atomic 16-bit write
        wr(6'h21, 8'h34);
        chk("period_l_staged", {16'b0, period[31:16]}, 32'd128);
        wr(6'h22, 8'h12);
        chk("period_h_commit", {16'b0, period[31:16]}, 32'h1234);
        chk("period_ch0_kept", {16'b0, period[15:0]}, 32'd128);
        rd(6'h21, 8'h34, "period_l_rb");
        rd(6'h22, 8'h12, "period_h_rb");
        wr(6'h14, 8'h05);
        chk("width_h_only", {16'b0, width[15:0]}, 32'h0501);

        // start / run
        wr(6'h17, 8'h03);
        chk("run_set", {30'b0, run_ppt}, 32'd1);
        chk("start_pulse", {30'b0, start_ppt}, 32'd1);
        @(negedge clk);
        chk("start_cleared", {30'b0, start_ppt}, 32'd0);
        chk("run_persist", {30'b0, run_ppt}, 32'd1);
        rd(6'h17, 8'h01, "ctrl_rb");
        wr(6'h17, 8'h03);
        chk("start_b2b_1", {30'b0, start_ppt}, 32'd1);
        wr(6'h17, 8'h03);
        chk("start_b2b_2", {30'b0, start_ppt}, 32'd1);

        // coherent count_done read
        count_done[15:0] = 16'h01FF;
        rd(6'h18, 8'hFF, "cnt_done_l");
        count_done[15:0] = 16'h0200;
        rd(6'h19, 8'h01, "cnt_done_h_snap");

        // interrupt
        wr(6'h02, 8'h02);
        done = 2'b10;
        @(negedge clk);
        chk("irq_after_edge1", {31'b0, irq}, 32'd0);
        @(negedge clk);
        chk("irq_after_edge2", {31'b0, irq}, 32'd1);
        rd(6'h03, 8'h02, "irq_status_set");
        wr(6'h03, 8'h02);
        @(negedge clk);
        chk("irq_cleared", {31'b0, irq}, 32'd0);
        rd(6'h03, 8'h00, "irq_status_clr");
        done = 2'b00;
        @(negedge clk);
        done = 2'b10;
        wr(6'h03, 8'h02);
        rd(6'h03, 8'h02, "irq_set_wins");
        chk("irq_set_wins_out", {31'b0, irq}, 32'd1);
        rd(6'h2A, 8'h01, "ch1_status");
        rd(6'h1A, 8'h00, "ch0_status");

        // ignored writes and reserved locations
        count_done[15:0] = 16'h0277;
        wr(6'h3B, 8'hFF);
        rd(6'h3B, 8'h00, "blk3_read");
        wr(6'h18, 8'h55);
        rd(6'h18, 8'h77, "cnt_done_ro");
        rd(6'h1B, 8'h00, "reserved_off");

        // same-cycle read and write
        address = 6'h12;
        data_in = 8'h07;
        write_enable = 1'b1;
        read_enable = 1'b1;
        exp_q.push_back(8'h00);
        name_q.push_back("rw_same_prewrite");
        @(negedge clk);
        write_enable = 1'b0;
        read_enable = 1'b0;
        rd(6'h12, 8'h07, "rw_same_after");
        chk("rw_same_period", {16'b0, period[15:0]}, 32'h0780);

        // reset during a write with staging loaded
        wr(6'h11, 8'h44);
        address = 6'h21;
        data_in = 8'h99;
        write_enable = 1'b1;
        #2 rst = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_period", period, {16'd128, 16'd128});
        chk("mid_rst_width", width, {16'd1, 16'd1});
        chk("mid_rst_count", count, {16'd16, 16'd16});
        chk("mid_rst_run", {30'b0, run_ppt}, 32'd0);
        chk("mid_rst_irq", {31'b0, irq}, 32'd0);
        chk("mid_rst_clk_div", {22'b0, clk_div}, {22'b0, 5'd9, 5'd9});
        wr(6'h12, 8'h00);
        chk("staging_discarded", {16'b0, period[15:0]}, 32'd128);
        rd(6'h03, 8'h02, "done_after_rst");
        rd(6'h02, 8'h00, "irq_en_rst");

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_drain: %0d reads pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
